// File: rtl/lock_controller.sv
// lock_controller: door-lock sequencer around an external code detector.
// Arms the detector on the start button, releases the latch on a correct
// code, counts consecutive failed attempts and locks out after too many.
//
// state   | meaning
// IDLE    | waiting for start button, detector held in reset
// ARMED   | detector running, waiting for success/abort/timeout
// OPEN    | latch released for a fixed number of cycles
// HOLD    | door physically open, latch re-engaged, wait for close
// LOCKOUT | too many failures, alarm on, all inputs ignored
module lock_controller #(
  parameter int UNLOCK_CYCLES  = 8,
  parameter int ENTRY_TIMEOUT  = 32,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int MAX_FAILS      = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       S,
  input  logic       U,
  input  logic       Fail,
  input  logic       DoorOpen,
  output logic       DetRst,
  output logic       DetStart,
  output logic       Latch,
  output logic       Alarm,
  output logic [1:0] FailCnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  // Last counter value of each timed state (counter starts at 0 on entry).
  localparam logic [7:0] ENTRY_LAST   = 8'(ENTRY_TIMEOUT - 1);
  localparam logic [7:0] UNLOCK_LAST  = 8'(UNLOCK_CYCLES - 1);
  localparam logic [7:0] LOCKOUT_LAST = 8'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0] FAIL_LIMIT   = 3'(MAX_FAILS);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [1:0] fail_cnt_nxt;
  logic [2:0] fail_inc;
  logic       timed_nxt;

  // Widened so the compare against MAX_FAILS cannot wrap.
  assign fail_inc = {1'b0, FailCnt} + 3'd1;

  // Start strobe is combinational so it coincides with the IDLE->ARMED edge.
  assign DetStart = Reset && (state == IDLE) && S;

  // Next-state and failure-count decision.
  always_comb begin
    state_nxt    = state;
    fail_cnt_nxt = FailCnt;
    case (state)
      IDLE: begin
        if (S) state_nxt = ARMED;
      end
      ARMED: begin
        if (U) begin
          state_nxt    = OPEN;
          fail_cnt_nxt = 2'd0;
        end else if (Fail || (cnt == ENTRY_LAST)) begin
          // On the lockout path the count stays at MAX_FAILS-1 (saturated).
          if (fail_inc == FAIL_LIMIT) begin
            state_nxt = LOCKOUT;
          end else begin
            state_nxt    = IDLE;
            fail_cnt_nxt = fail_inc[1:0];
          end
        end
      end
      OPEN: begin
        if (DoorOpen)                state_nxt = HOLD;
        else if (cnt == UNLOCK_LAST) state_nxt = IDLE;
      end
      HOLD: begin
        if (!DoorOpen) state_nxt = IDLE;
      end
      LOCKOUT: begin
        if (cnt == LOCKOUT_LAST) begin
          state_nxt    = IDLE;
          fail_cnt_nxt = 2'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the timed states advance the shared counter.
  assign timed_nxt = (state_nxt == ARMED) || (state_nxt == OPEN) || (state_nxt == LOCKOUT);

  // State, counter, failure count and Moore outputs registered together.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      FailCnt <= 2'd0;
      DetRst  <= 1'b1;
      Latch   <= 1'b0;
      Alarm   <= 1'b0;
    end else begin
      state   <= state_nxt;
      FailCnt <= fail_cnt_nxt;
      if ((state_nxt != state) || !timed_nxt) cnt <= 8'd0;
      else                                    cnt <= cnt + 8'd1;
      DetRst  <= (state_nxt != ARMED);
      Latch   <= (state_nxt == OPEN);
      Alarm   <= (state_nxt == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed stimulus with a phase/remaining-time model
// of the lock, compared against the DUT every cycle.
module tb_lock_controller;

  localparam int UNLOCK_CYCLES  = 8;
  localparam int ENTRY_TIMEOUT  = 32;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int MAX_FAILS      = 3;

  localparam int M_WAIT   = 0;
  localparam int M_ENTER  = 1;
  localparam int M_UNLOCK = 2;
  localparam int M_HELD   = 3;
  localparam int M_ALARM  = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       S;
  logic       U;
  logic       Fail;
  logic       DoorOpen;
  logic       DetRst;
  logic       DetStart;
  logic       Latch;
  logic       Alarm;
  logic [1:0] FailCnt;

  int checks = 0;
  int errors = 0;

  int m_mode  = M_WAIT;
  int m_left  = 0;
  int m_fails = 0;

  int latch_seen = 0;
  int alarm_seen = 0;
  int armed_seen = 0;
  int base;

  lock_controller #(
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .ENTRY_TIMEOUT (ENTRY_TIMEOUT),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .MAX_FAILS     (MAX_FAILS)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .S       (S),
    .U       (U),
    .Fail    (Fail),
    .DoorOpen(DoorOpen),
    .DetRst  (DetRst),
    .DetStart(DetStart),
    .Latch   (Latch),
    .Alarm   (Alarm),
    .FailCnt (FailCnt)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model's current phase and inputs.
  task automatic compare_cycle();
    check_bit("DetRst",   DetRst,   m_mode != M_ENTER);
    check_bit("DetStart", DetStart, (m_mode == M_WAIT) && S && Reset);
    check_bit("Latch",    Latch,    m_mode == M_UNLOCK);
    check_bit("Alarm",    Alarm,    m_mode == M_ALARM);
    check_int("FailCnt",  int'(FailCnt), m_fails);
    if (Latch)   latch_seen++;
    if (Alarm)   alarm_seen++;
    if (!DetRst) armed_seen++;
  endtask

  // Advance the model across the upcoming rising edge.
  task automatic model_step();
    if (!Reset) begin
      m_mode  = M_WAIT;
      m_left  = 0;
      m_fails = 0;
    end else begin
      case (m_mode)
        M_WAIT: begin
          if (S) begin
            m_mode = M_ENTER;
            m_left = ENTRY_TIMEOUT;
          end
        end
        M_ENTER: begin
          m_left = m_left - 1;
          if (U) begin
            m_mode  = M_UNLOCK;
            m_left  = UNLOCK_CYCLES;
            m_fails = 0;
          end else if (Fail || m_left == 0) begin
            if (m_fails + 1 >= MAX_FAILS) begin
              m_mode = M_ALARM;
              m_left = LOCKOUT_CYCLES;
            end else begin
              m_fails = m_fails + 1;
              m_mode  = M_WAIT;
            end
          end
        end
        M_UNLOCK: begin
          m_left = m_left - 1;
          if (DoorOpen)         m_mode = M_HELD;
          else if (m_left == 0) m_mode = M_WAIT;
        end
        M_HELD: begin
          if (!DoorOpen) m_mode = M_WAIT;
        end
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode  = M_WAIT;
            m_fails = 0;
          end
        end
      endcase
    end
  endtask

  task automatic drive(input logic s, input logic u, input logic f, input logic d, input logic r);
    @(negedge Clk);
    S = s; U = u; Fail = f; DoorOpen = d; Reset = r;
    #2;
    compare_cycle();
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic attempt_fail();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    Reset = 1'b0; S = 1'b0; U = 1'b0; Fail = 1'b0; DoorOpen = 1'b0;

    // Reset for two cycles, second one with competing inputs.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_bit("rst_detrst", DetRst, 1'b1);
    check_bit("rst_detstart", DetStart, 1'b0);
    check_bit("rst_latch", Latch, 1'b0);

    // Start, hold S into ARMED, unlock.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("start_strobe", DetStart, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("no_restrobe", DetStart, 1'b0);
    check_bit("armed_detrst", DetRst, 1'b0);
    idle(2);
    base = latch_seen;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(12);
    check_int("unlock_len", latch_seen - base, 8);
    check_int("unlock_failcnt", int'(FailCnt), 0);

    // U/Fail in IDLE ignored, then three aborted attempts into lockout.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    attempt_fail();
    idle(1);
    check_int("fail1", int'(FailCnt), 1);
    attempt_fail();
    idle(1);
    check_int("fail2", int'(FailCnt), 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    base = alarm_seen;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_bit("lock_alarm", Alarm, 1'b1);
    check_int("lock_failcnt", int'(FailCnt), 2);
    idle(10);
    check_int("alarm_len", alarm_seen - base, 16);
    check_int("lock_exit_failcnt", int'(FailCnt), 0);
    check_int("model_lock_exit", m_fails, 0);

    // Timeout with no detector response.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    base = armed_seen;
    idle(40);
    check_int("armed_len", armed_seen - base, 32);
    check_int("timeout_failcnt", int'(FailCnt), 1);
    check_int("model_timeout", m_fails, 1);

    // U and Fail together with two failures pending.
    attempt_fail();
    idle(1);
    check_int("pre_both_failcnt", int'(FailCnt), 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("both_latch", Latch, 1'b1);
    check_bit("both_alarm", Alarm, 1'b0);
    check_int("both_failcnt", int'(FailCnt), 0);
    idle(10);

    // Door opened in the fourth OPEN cycle, held open for 20 cycles.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    base = latch_seen;
    idle(3);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_bit("hold_latch", Latch, 1'b0);
    check_int("open_len", latch_seen - base, 4);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("idle_after_hold", DetStart, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Back into lockout, then reset in its eighth cycle.
    attempt_fail();
    attempt_fail();
    idle(7);
    check_bit("pre_rst_alarm", Alarm, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("lockrst_alarm", Alarm, 1'b0);
    check_bit("lockrst_detrst", DetRst, 1'b1);
    check_int("lockrst_failcnt", int'(FailCnt), 0);

    // Reset mid-OPEN and mid-ARMED with a failure pending.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_bit("openrst_latch", Latch, 1'b0);
    attempt_fail();
    idle(1);
    check_int("pre_armrst_failcnt", int'(FailCnt), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_int("armrst_failcnt", int'(FailCnt), 0);
    check_bit("armrst_detrst", DetRst, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
